// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a 64-bit word SRAM: independent single-outstanding read and
// write burst engines with FIXED/INCR/WRAP addressing and per-beat address decode.
module axi_sram_slave #(
  parameter int          MEM_DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic [1:0]  dbg_wr_state,
  output logic        dbg_rd_state
);
  localparam int          DEPTH       = 1 << MEM_DEPTH_LOG2;
  localparam logic [32:0] SPAN        = 33'd8 << MEM_DEPTH_LOG2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  logic [63:0] mem [DEPTH];

  // {in_range, word_index}
  function automatic logic [MEM_DEPTH_LOG2:0] decode(input logic [31:0] a);
    logic [31:0] off;
    off    = a - BASE_ADDR;
    decode = {(a >= BASE_ADDR) && ({1'b0, off} < SPAN), off[MEM_DEPTH_LOG2+2:3]};
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr, bound;
    incr  = a + (32'd1 << size);
    bound = ({24'd0, len} + 32'd1) << size;
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~(bound - 32'd1)) | (incr & (bound - 32'd1));
      default:     next_addr = incr;
    endcase
  endfunction

  // {slverr, effective size, effective burst}; illegal shapes fall back to INCR
  function automatic logic [5:0] norm_cfg(input logic [7:0] len, input logic [2:0] size,
                                          input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    if (size > 3'd3 || bad_wrap) norm_cfg = {1'b1, 3'd3, BURST_INCR};
    else if (burst == 2'b11)     norm_cfg = {1'b1, size, BURST_INCR};
    else                         norm_cfg = {1'b0, size, burst};
  endfunction

  // All channels: a transfer happens on a rising edge where valid and ready are both 1;
  // the master holds valid and payload until then, and ready never depends on valid here.
  logic init_done;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) init_done <= 1'b0;
    else          init_done <= 1'b1;

  // ---------------- write path ----------------
  wr_state_t wr_state, wr_next;
  logic                      aw_hs, w_hs, wr_last_beat, wr_in_range;
  logic [3:0]                aw_id;
  logic [31:0]               wr_addr;
  logic [7:0]                wr_len, wr_cnt;
  logic [2:0]                wr_size;
  logic [1:0]                wr_burst, wr_resp, wr_beat_resp;
  logic [5:0]                aw_cfg;
  logic [MEM_DEPTH_LOG2:0]   wr_dec;
  logic [MEM_DEPTH_LOG2-1:0] wr_idx;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_next;

  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready = init_done;
        if (awvalid && init_done) wr_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wr_last_beat) wr_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  assign aw_hs        = awvalid && awready;
  assign w_hs         = wvalid && wready;
  assign aw_cfg       = norm_cfg(awlen, awsize, awburst);
  assign wr_last_beat = (wr_cnt == wr_len);
  assign wr_dec       = decode(wr_addr);
  assign wr_in_range  = wr_dec[MEM_DEPTH_LOG2];
  assign wr_idx       = wr_dec[MEM_DEPTH_LOG2-1:0];
  assign wr_beat_resp = !wr_in_range             ? RESP_DECERR :
                        (wlast != wr_last_beat)  ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      aw_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_resp  <= RESP_OKAY;
    end else if (aw_hs) begin
      aw_id    <= awid;
      wr_addr  <= awaddr;
      wr_len   <= awlen;
      wr_cnt   <= '0;
      wr_size  <= aw_cfg[4:2];
      wr_burst <= aw_cfg[1:0];
      wr_resp  <= aw_cfg[5] ? RESP_SLVERR : RESP_OKAY;
    end else if (w_hs) begin
      wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst);
      wr_cnt  <= wr_cnt + 8'd1;
      // response codes are ordered so the numerically larger one is the worse one
      if (wr_beat_resp > wr_resp) wr_resp <= wr_beat_resp;
    end

  // storage has no reset so contents survive aresetn
  always_ff @(posedge aclk)
    if (w_hs && wr_in_range)
      for (int i = 0; i < 8; i++)
        if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];

  assign bid   = aw_id;
  assign bresp = bvalid ? wr_resp : RESP_OKAY;

  // ---------------- read path ----------------
  rd_state_t rd_state, rd_next;
  logic                      ar_hs, r_hs, rd_cfg_err, rd_load_err, rd_load_ok;
  logic [31:0]               rd_addr, rd_load_addr;
  logic [7:0]                rd_len, rd_cnt;
  logic [2:0]                rd_size;
  logic [1:0]                rd_burst, rd_load_resp;
  logic [5:0]                ar_cfg;
  logic [63:0]               rd_load_data;
  logic [MEM_DEPTH_LOG2:0]   rd_dec;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_next;

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready = init_done;
        if (arvalid && init_done) rd_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign ar_cfg = norm_cfg(arlen, arsize, arburst);

  // the word loaded this edge: first beat from araddr, later beats from the advanced address
  assign rd_load_addr = (rd_state == R_IDLE) ? araddr
                                             : next_addr(rd_addr, rd_len, rd_size, rd_burst);
  assign rd_load_err  = (rd_state == R_IDLE) ? ar_cfg[5] : rd_cfg_err;
  assign rd_dec       = decode(rd_load_addr);
  assign rd_load_ok   = rd_dec[MEM_DEPTH_LOG2];
  assign rd_load_data = rd_load_ok ? mem[rd_dec[MEM_DEPTH_LOG2-1:0]] : 64'd0;
  assign rd_load_resp = !rd_load_ok ? RESP_DECERR : rd_load_err ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rid        <= '0;
      rd_addr    <= '0;
      rd_len     <= '0;
      rd_cnt     <= '0;
      rd_size    <= '0;
      rd_burst   <= '0;
      rd_cfg_err <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
      rlast      <= 1'b0;
    end else if (ar_hs) begin
      rid        <= arid;
      rd_addr    <= araddr;
      rd_len     <= arlen;
      rd_cnt     <= '0;
      rd_size    <= ar_cfg[4:2];
      rd_burst   <= ar_cfg[1:0];
      rd_cfg_err <= ar_cfg[5];
      rdata      <= rd_load_data;
      rresp      <= rd_load_resp;
      rlast      <= (arlen == 8'd0);
    end else if (r_hs) begin
      if (!rlast) begin
        rd_addr <= rd_load_addr;
        rd_cnt  <= rd_cnt + 8'd1;
        rdata   <= rd_load_data;
        rresp   <= rd_load_resp;
        rlast   <= (rd_cnt + 8'd1 == rd_len);
      end else begin
        rlast <= 1'b0;
      end
    end

  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read bursts, strobes, wrap, decode errors,
// wlast errors, read/write collision and mid-burst reset.
module tb_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [1:0]  dbg_wr_state;
  logic        dbg_rd_state;

  int n_vec = 0;
  int n_err = 0;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  function automatic logic [63:0] wv(input int i);
    wv = 64'hC0DE_F00D_0000_0000 | 64'(i);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drv_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("FAIL aw_timeout awready=%b required=1", awready);
    end
    @(posedge aclk); #1 awvalid = 1'b0;
  endtask

  task automatic drv_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("FAIL w_timeout wready=%b required=1", wready);
    end
    @(posedge aclk); #1 wvalid = 1'b0;
  endtask

  task automatic drv_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("FAIL ar_timeout arready=%b required=1", arready);
    end
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("FAIL b_timeout bvalid=%b required=1", bvalid);
    end
  endtask

  task automatic ack_b();
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [63:0] data);
    drv_aw(4'd0, addr, 8'd0, 3'd3, 2'b01);
    drv_w(data, 8'hFF, 1'b1);
    wait_b();
    ack_b();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    n_vec++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl got=%b required=000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    n_vec++;
    if ({bid, bresp, rid, rresp, rdata, dbg_wr_state, dbg_rd_state} !== '0) begin
      n_err++;
      $display("FAIL reset_data bid=%h bresp=%h rid=%h rresp=%h rdata=%h st=%h/%h required all 0",
               bid, bresp, rid, rresp, rdata, dbg_wr_state, dbg_rd_state);
    end
    aresetn = 1'b1;
    #1;
    n_vec++;
    if ({awready, arready} !== 2'b00) begin
      n_err++;
      $display("FAIL ready_before_edge got=%b required=00", {awready, arready});
    end
    @(posedge aclk); #1;
    n_vec++;
    if ({awready, arready} !== 2'b11) begin
      n_err++;
      $display("FAIL ready_after_edge got=%b required=11", {awready, arready});
    end
  endtask

  task automatic test_single();
    drv_aw(4'd3, BASE + 32'h10, 8'd0, 3'd3, 2'b01);
    drv_w(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    wait_b();
    n_vec++;
    if ({bid, bresp} !== {4'd3, 2'b00}) begin
      n_err++;
      $display("FAIL single_b got id=%h resp=%b required id=3 resp=00", bid, bresp);
    end
    ack_b();
    n_vec++;
    if (bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_b_drop bvalid=%b required=0", bvalid);
    end
    drv_ar(4'd3, BASE + 32'h10, 8'd0, 3'd3, 2'b01);
    n_vec++;
    if ({rvalid, rdata, rid, rresp, rlast} !== {1'b1, 64'h1122_3344_5566_7788, 4'd3, 2'b00, 1'b1}) begin
      n_err++;
      $display("FAIL single_r got v=%b d=%h id=%h resp=%b last=%b required v=1 d=1122334455667788 id=3 resp=00 last=1",
               rvalid, rdata, rid, rresp, rlast);
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_r_end rvalid=%b required=0", rvalid);
    end
  endtask

  task automatic test_partial();
    write_word(BASE, 64'd0);
    drv_aw(4'd1, BASE, 8'd0, 3'd3, 2'b01);
    drv_w(64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b1);
    wait_b();
    ack_b();
    drv_ar(4'd1, BASE, 8'd0, 3'd3, 2'b01);
    n_vec++;
    if ({rdata, rresp} !== {64'h0000_0000_AAAA_AAAA, 2'b00}) begin
      n_err++;
      $display("FAIL partial_strb got d=%h resp=%b required d=00000000aaaaaaaa resp=00", rdata, rresp);
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
  endtask

  task automatic test_stall();
    drv_aw(4'd2, BASE, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) drv_w(wv(i), 8'hFF, i == 3);
    wait_b();
    n_vec++;
    if ({bid, bresp} !== {4'd2, 2'b00}) begin
      n_err++;
      $display("FAIL stall_b got id=%h resp=%b required id=2 resp=00", bid, bresp);
    end
    ack_b();
    drv_ar(4'd2, BASE, 8'd3, 3'd3, 2'b01);
    for (int b = 0; b < 4; b++) begin
      @(negedge aclk);
      n_vec++;
      if ({rvalid, rdata, rlast} !== {1'b1, wv(b), b == 3}) begin
        n_err++;
        $display("FAIL stall_beat%0d got v=%b d=%h last=%b required v=1 d=%h last=%b",
                 b, rvalid, rdata, rlast, wv(b), b == 3);
      end
      rready = 1'b0;
      @(negedge aclk);
      n_vec++;
      if ({rvalid, rdata, rlast} !== {1'b1, wv(b), b == 3}) begin
        n_err++;
        $display("FAIL stall_hold%0d got v=%b d=%h last=%b required v=1 d=%h last=%b",
                 b, rvalid, rdata, rlast, wv(b), b == 3);
      end
      rready = 1'b1;
      @(posedge aclk); #1 rready = 1'b0;
    end
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end rvalid=%b required=0", rvalid);
    end
  endtask

  task automatic test_wrap();
    int order [4];
    order = '{3, 0, 1, 2};
    drv_ar(4'd6, BASE + 32'h18, 8'd3, 3'd3, 2'b10);
    rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      n_vec++;
      if ({rvalid, rdata, rid, rresp, rlast} !== {1'b1, wv(order[b]), 4'd6, 2'b00, b == 3}) begin
        n_err++;
        $display("FAIL wrap_beat%0d got v=%b d=%h id=%h resp=%b last=%b required d=%h id=6 resp=00 last=%b",
                 b, rvalid, rdata, rid, rresp, rlast, wv(order[b]), b == 3);
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_end rvalid=%b required=0", rvalid);
    end
  endtask

  task automatic test_decode();
    write_word(BASE + 32'h1000, 64'h5A5A_5A5A_1234_5678);
    drv_aw(4'd5, 32'h0000_1000, 8'd1, 3'd3, 2'b01);
    drv_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b0);
    drv_w(64'hFEED_FACE_FEED_FACE, 8'hFF, 1'b1);
    wait_b();
    n_vec++;
    if ({bid, bresp} !== {4'd5, 2'b11}) begin
      n_err++;
      $display("FAIL decerr_b got id=%h resp=%b required id=5 resp=11", bid, bresp);
    end
    ack_b();
    drv_ar(4'd5, BASE + 32'h1000, 8'd0, 3'd3, 2'b01);
    n_vec++;
    if ({rdata, rresp} !== {64'h5A5A_5A5A_1234_5678, 2'b00}) begin
      n_err++;
      $display("FAIL decerr_mem got d=%h resp=%b required d=5a5a5a5a12345678 resp=00", rdata, rresp);
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
    drv_ar(4'd5, 32'h0000_1000, 8'd0, 3'd3, 2'b01);
    n_vec++;
    if ({rdata, rresp, rlast} !== {64'd0, 2'b11, 1'b1}) begin
      n_err++;
      $display("FAIL decerr_r got d=%h resp=%b last=%b required d=0 resp=11 last=1", rdata, rresp, rlast);
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
    drv_aw(4'd7, BASE + 32'h40, 8'd1, 3'd3, 2'b01);
    drv_w(64'h1, 8'hFF, 1'b1);
    n_vec++;
    if ({bvalid, wready} !== 2'b01) begin
      n_err++;
      $display("FAIL early_last_wait got bvalid=%b wready=%b required bvalid=0 wready=1", bvalid, wready);
    end
    drv_w(64'h2, 8'hFF, 1'b1);
    wait_b();
    n_vec++;
    if ({bid, bresp} !== {4'd7, 2'b10}) begin
      n_err++;
      $display("FAIL early_last_b got id=%h resp=%b required id=7 resp=10", bid, bresp);
    end
    ack_b();
    drv_aw(4'd8, BASE + 32'h50, 8'd0, 3'd3, 2'b01);
    drv_w(64'h3, 8'hFF, 1'b0);
    wait_b();
    n_vec++;
    if ({bid, bresp} !== {4'd8, 2'b10}) begin
      n_err++;
      $display("FAIL missing_last_b got id=%h resp=%b required id=8 resp=10", bid, bresp);
    end
    ack_b();
  endtask

  task automatic test_boundary();
    write_word(BASE + 32'h7FF8, 64'h0BAD_CAFE_0000_7FF8);
    drv_ar(4'd9, BASE + 32'h7FF8, 8'd1, 3'd3, 2'b01);
    rready = 1'b1;
    n_vec++;
    if ({rdata, rresp, rlast} !== {64'h0BAD_CAFE_0000_7FF8, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL top_word got d=%h resp=%b last=%b required d=0badcafe00007ff8 resp=00 last=0", rdata, rresp, rlast);
    end
    @(posedge aclk); #1;
    n_vec++;
    if ({rvalid, rdata, rresp, rlast} !== {1'b1, 64'd0, 2'b11, 1'b1}) begin
      n_err++;
      $display("FAIL past_top got v=%b d=%h resp=%b last=%b required v=1 d=0 resp=11 last=1", rvalid, rdata, rresp, rlast);
    end
    @(posedge aclk); #1 rready = 1'b0;
    drv_ar(4'd1, BASE + 32'h10, 8'd0, 3'd3, 2'b11);
    n_vec++;
    if ({rdata, rresp} !== {wv(2), 2'b10}) begin
      n_err++;
      $display("FAIL rsvd_burst got d=%h resp=%b required d=%h resp=10", rdata, rresp, wv(2));
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
    drv_ar(4'd1, BASE, 8'd0, 3'd4, 2'b01);
    n_vec++;
    if ({rdata, rresp} !== {wv(0), 2'b10}) begin
      n_err++;
      $display("FAIL big_size got d=%h resp=%b required d=%h resp=10", rdata, rresp, wv(0));
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
    // WRAP with len=2 is illegal: behaves as INCR size 3 from word 1
    drv_ar(4'd2, BASE + 32'h08, 8'd2, 3'd3, 2'b10);
    rready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      n_vec++;
      if ({rdata, rresp, rlast} !== {wv(b + 1), 2'b10, b == 2}) begin
        n_err++;
        $display("FAIL bad_wrap%0d got d=%h resp=%b last=%b required d=%h resp=10 last=%b",
                 b, rdata, rresp, rlast, wv(b + 1), b == 2);
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic test_collision();
    write_word(BASE + 32'h28, 64'h0000_0000_0000_01D0);
    drv_aw(4'd9, BASE + 32'h28, 8'd0, 3'd3, 2'b01);
    wdata = 64'h0000_0000_0000_0E55; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd9; araddr = BASE + 32'h28; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    n_vec++;
    if ({wready, arready} !== 2'b11) begin
      n_err++;
      $display("FAIL collide_ready got wready=%b arready=%b required 1 1", wready, arready);
    end
    @(posedge aclk); #1 wvalid = 1'b0; arvalid = 1'b0;
    n_vec++;
    if (rdata !== 64'h0000_0000_0000_01D0) begin
      n_err++;
      $display("FAIL collide_old got d=%h required d=00000000000001d0", rdata);
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
    wait_b();
    ack_b();
    drv_ar(4'd9, BASE + 32'h28, 8'd0, 3'd3, 2'b01);
    n_vec++;
    if (rdata !== 64'h0000_0000_0000_0E55) begin
      n_err++;
      $display("FAIL collide_new got d=%h required d=0000000000000e55", rdata);
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drv_ar(4'd4, BASE, 8'd7, 3'd3, 2'b01);
    rready = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    n_vec++;
    if ({rvalid, rdata} !== {1'b1, wv(2)}) begin
      n_err++;
      $display("FAIL mid_beat2 got v=%b d=%h required v=1 d=%h", rvalid, rdata, wv(2));
    end
    aresetn = 1'b0;
    rready = 1'b0;
    #1;
    n_vec++;
    if ({rvalid, rlast, arready, awready, rdata} !== {4'b0000, 64'd0}) begin
      n_err++;
      $display("FAIL mid_reset got v=%b last=%b arready=%b awready=%b d=%h required all 0",
               rvalid, rlast, arready, awready, rdata);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    n_vec++;
    if (arready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rearm arready=%b required=1", arready);
    end
    drv_ar(4'd11, BASE + 32'h10, 8'd0, 3'd3, 2'b01);
    n_vec++;
    if ({rvalid, rdata, rid, rresp, rlast} !== {1'b1, wv(2), 4'd11, 2'b00, 1'b1}) begin
      n_err++;
      $display("FAIL mid_after got v=%b d=%h id=%h resp=%b last=%b required v=1 d=%h id=b resp=00 last=1",
               rvalid, rdata, rid, rresp, rlast, wv(2));
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_after_end rvalid=%b required=0", rvalid);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_partial();
    test_stall();
    test_wrap();
    test_decode();
    test_boundary();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
